pipeif_queue: RTL
=================

# pipeif_queue

Two-entry instruction fetch queue between the PC/instruction-memory fetch stage and the decode stage of the pipelined CPU. It captures {pc+4, instruction} pairs, presents them to ID with a valid/ready handshake, and drives the PC write enable through `f_ready`, so the fetch stage keeps running for up to two cycles while ID stalls. A branch/jump resolved in ID squashes all queued work through `flush`.

## Interface
Parameters: none.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `clr` input 1: reset, synchronous, active-high.
- `f_pc4` input 32: pc+4 of the instruction being fetched.
- `f_ins` input 32: instruction word from instruction memory.
- `f_valid` input 1: fetch side offers `f_pc4`/`f_ins` this cycle.
- `f_ready` output 1: queue accepts this cycle; wired to the PC register write enable.
- `d_pc4` output 32: pc+4 of the head entry.
- `d_ins` output 32: head instruction.
- `d_valid` output 1: head entry valid.
- `d_ready` input 1: ID consumes the head this cycle (0 = ID stall).
- `flush` input 1: discard all entries (taken branch/jump from ID).
- `count` output 2: occupancy, 0..2.
- `stall_cnt` output 32: fetch-stall cycle counter (see Configuration).

## Operation
- Storage: `slot0` (head) and `slot1`, each {pc4[31:0], ins[31:0]}, plus `count[1:0]`. The only legal count values are 0, 1 and 2.
- `d_pc4`/`d_ins` come straight from `slot0` registers. There is no combinational path from `f_*` to `d_*`.
- `d_valid` = (count != 0).
- `f_ready` = !clr && (count != 2). It has no dependence on `d_ready` or `flush`.
- Push = f_valid && f_ready && !flush.
- Pop = d_valid && d_ready.
- Next state, in priority order:
  - `clr`: count=0; slot0=slot1=0.
  - `flush`: count=0; slot0=slot1=0. A pop in the same cycle counts as completed; the push is dropped.
  - Pop only:
    - count 1→0: slot0=0.
    - count 2→1: slot0=slot1; slot1=0.
  - Push only:
    - count 0→1: slot0=new.
    - count 1→2: slot1=new.
  - Push and pop:
    - count 1: slot0=new, count stays 1.
    - count 2: cannot occur, because f_ready=0.
  - Neither push nor pop: hold.
- Empty queue: d_ins=32'h0 (nop) and d_pc4=32'h0, because slots are zeroed whenever they are vacated.
- Ordering: strict FIFO. No entry is duplicated or reordered.

## Timing
- Reset values: count=0, d_valid=0, d_ins=0, d_pc4=0, stall_cnt=0. While clr=1, f_ready=0.
- Latency: a push at edge N into an empty queue gives d_valid=1 with that entry in the cycle after edge N. Minimum fetch-to-decode latency is 1 cycle.
- Throughput: 1 entry/cycle at count=1 when f_valid=d_ready=1 continuously.
- Back-pressure: with d_ready=0, the queue accepts 2 entries, then f_ready drops to 0 and the PC holds. f_ready rises again in the cycle after the first pop.
- Flush: takes effect at the edge where flush=1. d_valid=0 in the following cycle. The fetch that is presented in the cycle after the flush (the redirected PC) is accepted normally.
- clr asserted mid-operation wins over flush, push and pop in that cycle.

## Configuration
- `PIPEIF_PERF_EN` defined:
  - `stall_cnt` increments by 1 on every edge where f_valid && !f_ready && !clr.
  - It saturates at 32'hFFFFFFFF.
  - clr zeroes it; flush does not affect it.
- `PIPEIF_PERF_EN` undefined: `stall_cnt` is tied to 32'h0. The port is retained and no counter logic is generated.

## Test plan
- Reset: clr=1 for 2 cycles, then 0 → count=0, d_valid=0, d_ins=0, f_ready=0 during clr and 1 after.
- Streaming: f_valid=d_ready=1, push pc4=4,8,12 with ins=A,B,C → d_ins=A,B,C on consecutive cycles; count stays 1; f_ready stays 1.
- Fill/stall: d_ready=0, push A then B → count=2, f_ready=0, and a third offer C is not accepted. Then d_ready=1 → A, B, C appear in order, and f_ready=1 the cycle after the first pop.
- Flush at count=2 with a simultaneous push D and pop → next cycle count=0, d_valid=0, d_ins=0, and D is never presented.
- Perf counter (macro defined): hold count=2 with f_valid=1 for 5 cycles → stall_cnt=5. Then assert clr → stall_cnt=0. With the macro undefined, stall_cnt stays 0 throughout.
- Reset priority: clr=1 together with flush, push and pop at count=1 → count=0 and slots zeroed; no entry survives.

Source files
------------

// File: rtl/pipeif_queue.sv
// pipeif_queue
//
// Two-entry instruction fetch queue that sits between the PC/instruction
// memory fetch stage and the decode (ID) stage. Each entry holds a
// {pc+4, instruction} pair. The queue lets fetch keep running for up to two
// cycles while ID stalls. A taken branch or jump resolved in ID discards
// every queued entry through flush.
//
// Ports
//   clk        in   1  single clock; all state changes on the rising edge
//   clr        in   1  synchronous active-high reset
//   f_pc4      in  32  pc+4 of the instruction being fetched
//   f_ins      in  32  instruction word from instruction memory
//   f_valid    in   1  fetch offers f_pc4/f_ins this cycle
//   f_ready    out  1  queue accepts this cycle (drives PC write enable)
//   d_pc4      out 32  pc+4 of the head entry
//   d_ins      out 32  head instruction (0 = nop when empty)
//   d_valid    out  1  head entry is valid
//   d_ready    in   1  ID consumes the head this cycle
//   flush      in   1  discard all entries
//   count      out  2  occupancy, 0..2
//   stall_cnt  out 32  fetch-stall cycle counter
//
// Build option
//   PIPEIF_PERF_EN  when defined, stall_cnt counts the cycles in which fetch
//                   offers an entry that the queue refuses. The counter
//                   saturates and is cleared only by clr. When the macro is
//                   undefined, stall_cnt is tied to zero and no counter is
//                   built.

module pipeif_queue (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] f_pc4,
    input  logic [31:0] f_ins,
    input  logic        f_valid,
    output logic        f_ready,
    output logic [31:0] d_pc4,
    output logic [31:0] d_ins,
    output logic        d_valid,
    input  logic        d_ready,
    input  logic        flush,
    output logic [1:0]  count,
    output logic [31:0] stall_cnt
);

    logic [31:0] slot0_pc4_q, slot0_pc4_d;
    logic [31:0] slot0_ins_q, slot0_ins_d;
    logic [31:0] slot1_pc4_q, slot1_pc4_d;
    logic [31:0] slot1_ins_q, slot1_ins_d;
    logic [1:0]  count_q,     count_d;

    logic push;
    logic pop;

    // f_ready looks only at clr and occupancy. Keeping it independent of
    // d_ready and flush keeps the PC write enable off the ID-stage timing
    // path.
    assign f_ready = !clr && (count_q != 2'd2);
    assign d_valid = (count_q != 2'd0);
    assign d_pc4   = slot0_pc4_q;
    assign d_ins   = slot0_ins_q;
    assign count   = count_q;

    assign push = f_valid && f_ready && !flush;
    assign pop  = d_valid && d_ready;

    always_comb begin
        slot0_pc4_d = slot0_pc4_q;
        slot0_ins_d = slot0_ins_q;
        slot1_pc4_d = slot1_pc4_q;
        slot1_ins_d = slot1_ins_q;
        count_d     = count_q;

        if (clr || flush) begin
            // A pop in a flush cycle still counts as completed. The slots
            // are cleared so that an empty queue presents a nop at pc4 = 0.
            slot0_pc4_d = 32'h0;
            slot0_ins_d = 32'h0;
            slot1_pc4_d = 32'h0;
            slot1_ins_d = 32'h0;
            count_d     = 2'd0;
        end else if (pop && !push) begin
            case (count_q)
                2'd1: begin
                    slot0_pc4_d = 32'h0;
                    slot0_ins_d = 32'h0;
                    count_d     = 2'd0;
                end
                2'd2: begin
                    slot0_pc4_d = slot1_pc4_q;
                    slot0_ins_d = slot1_ins_q;
                    slot1_pc4_d = 32'h0;
                    slot1_ins_d = 32'h0;
                    count_d     = 2'd1;
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end else if (push && !pop) begin
            case (count_q)
                2'd0: begin
                    slot0_pc4_d = f_pc4;
                    slot0_ins_d = f_ins;
                    count_d     = 2'd1;
                end
                2'd1: begin
                    slot1_pc4_d = f_pc4;
                    slot1_ins_d = f_ins;
                    count_d     = 2'd2;
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end else if (push && pop) begin
            // A push together with a pop is only possible at count 1, because
            // f_ready is low at count 2. The new entry replaces the departing
            // head, so occupancy stays at 1.
            if (count_q == 2'd1) begin
                slot0_pc4_d = f_pc4;
                slot0_ins_d = f_ins;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            slot0_pc4_q <= 32'h0;
            slot0_ins_q <= 32'h0;
            slot1_pc4_q <= 32'h0;
            slot1_ins_q <= 32'h0;
            count_q     <= 2'd0;
        end else begin
            slot0_pc4_q <= slot0_pc4_d;
            slot0_ins_q <= slot0_ins_d;
            slot1_pc4_q <= slot1_pc4_d;
            slot1_ins_q <= slot1_ins_d;
            count_q     <= count_d;
        end
    end

`ifdef PIPEIF_PERF_EN
    logic [31:0] stall_cnt_q;

    // A stall cycle is one in which fetch offers an entry and the queue
    // refuses it. f_ready is already low during clr, so clr is excluded
    // explicitly. Flush does not touch the counter.
    always_ff @(posedge clk) begin
        if (clr) begin
            stall_cnt_q <= 32'h0;
        end else if (f_valid && !f_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule
